// File: rtl/parametric_mux.sv
// parametric_mux: N-way DATA_WIDTH-bit multiplexer.
// The selected word appears combinationally on BUS_OUT; an enable-gated register
// keeps a copy on BUS_OUT_Q, and VALID_OUT marks copies taken from an in-range select.
module parametric_mux #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    NUM_INPUTS    = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
    localparam int                   SW            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] BUS_IN [NUM_INPUTS],
    input  logic [SW-1:0]         SEL_IN,
    input  logic                  EN_IN,
    output logic [DATA_WIDTH-1:0] BUS_OUT,
    output logic                  SEL_ERR_OUT,
    output logic [DATA_WIDTH-1:0] BUS_OUT_Q,
    output logic                  VALID_OUT
);

    // Reject configurations that cannot describe a mux.
    if (NUM_INPUTS < 1) begin : g_bad_num_inputs
        $fatal(1, "parametric_mux: NUM_INPUTS must be >= 1 (got %0d)", NUM_INPUTS);
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "parametric_mux: DATA_WIDTH must be >= 1 (got %0d)", DATA_WIDTH);
    end

    logic [DATA_WIDTH-1:0] w_bus_sel;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] r_bus_q;
    logic                  r_valid;

    // Steer the indexed word onto the output. Only the matching input is ever read,
    // so X/Z on unselected inputs cannot leak through; an unmatched select
    // (out of range) leaves the default word in place.
    always_comb begin
        // NOTE: assign a default before any conditional write so no path leaves
        // w_bus_sel unassigned, which would otherwise infer a latch.
        w_bus_sel = DEFAULT_VALUE;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_IN == SW'(i)) begin
                w_bus_sel = BUS_IN[i];
            end
        end
    end

    // A select can only run past the last input when NUM_INPUTS does not fill the
    // select range; otherwise the error flag is tied low.
    if (NUM_INPUTS == (2 ** SW)) begin : g_full_range
        assign w_sel_err = 1'b0;
    end else begin : g_partial_range
        assign w_sel_err = ({1'b0, SEL_IN} >= (SW + 1)'(NUM_INPUTS));
    end

    assign BUS_OUT     = w_bus_sel;
    assign SEL_ERR_OUT = w_sel_err;

    // Capture the selected word and its validity when enabled; reset clears both at once.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            r_bus_q <= '0;
            r_valid <= 1'b0;
        end else if (EN_IN) begin
            r_bus_q <= w_bus_sel;
            r_valid <= ~w_sel_err;
        end
    end

    assign BUS_OUT_Q = r_bus_q;
    assign VALID_OUT = r_valid;

endmodule

// File: tb/tb_parametric_mux.sv
// Self-checking bench for parametric_mux: three configurations (8 inputs,
// 5 inputs with default DEAD, 1 input with default BEEF) against a behavioural model.
module tb_parametric_mux;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 8-input instance
    logic [DW-1:0] bus8 [8];
    logic [2:0]    sel8 = '0;
    logic          en8  = 1'b0;
    logic [DW-1:0] out8, q8;
    logic          err8, v8;

    // 5-input instance, out-of-range default DEAD
    logic [DW-1:0] bus5 [5];
    logic [2:0]    sel5 = '0;
    logic          en5  = 1'b0;
    logic [DW-1:0] out5, q5;
    logic          err5, v5;

    // 1-input instance, out-of-range default BEEF
    logic [DW-1:0] bus1 [1];
    logic          sel1 = 1'b0;
    logic          en1  = 1'b0;
    logic [DW-1:0] out1, q1;
    logic          err1, v1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    parametric_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(8), .DEFAULT_VALUE(16'h0000)) u_mux8 (
        .CLK(clk), .RST(rst), .BUS_IN(bus8), .SEL_IN(sel8), .EN_IN(en8),
        .BUS_OUT(out8), .SEL_ERR_OUT(err8), .BUS_OUT_Q(q8), .VALID_OUT(v8)
    );

    parametric_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(5), .DEFAULT_VALUE(16'hDEAD)) u_mux5 (
        .CLK(clk), .RST(rst), .BUS_IN(bus5), .SEL_IN(sel5), .EN_IN(en5),
        .BUS_OUT(out5), .SEL_ERR_OUT(err5), .BUS_OUT_Q(q5), .VALID_OUT(v5)
    );

    parametric_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(1), .DEFAULT_VALUE(16'hBEEF)) u_mux1 (
        .CLK(clk), .RST(rst), .BUS_IN(bus1), .SEL_IN(sel1), .EN_IN(en1),
        .BUS_OUT(out1), .SEL_ERR_OUT(err1), .BUS_OUT_Q(q1), .VALID_OUT(v1)
    );

    // Compare observed against expected with 4-state equality, so X bits fail too.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference rule for the 5-input mux: indexed word when in range, else DEAD.
    function automatic logic [DW-1:0] model5(input int sel, input logic [DW-1:0] words [5]);
        return (sel < 5) ? words[sel] : 16'hDEAD;
    endfunction

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run is a few hundred cycles; anything far beyond that is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] word;
        logic [DW-1:0] exp_q;
        logic          exp_v;
        int            s;

        for (int i = 0; i < 8; i++) bus8[i] = '0;
        for (int i = 0; i < 5; i++) bus5[i] = '0;
        bus1[0] = '0;

        // Reset state, held across clock edges even with enable high.
        en8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q8",  q8, 16'h0000);
        check("rst_v8",  v8, 1'b0);
        check("rst_q5",  q5, 16'h0000);
        check("rst_v5",  v5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en8 = 1'b0;

        // Random sweep: only the selected input is defined, the rest are X.
        for (int it = 0; it < 50; it++) begin
            s    = $urandom_range(0, 7);
            word = 16'($urandom);
            for (int i = 0; i < 8; i++) bus8[i] = 'x;
            bus8[s] = word;
            sel8    = 3'(s);
            #1;
            check($sformatf("sweep_out[%0d]", it), out8, word);
            check($sformatf("sweep_err[%0d]", it), err8, 1'b0);
        end

        // Boundary indices.
        for (int i = 0; i < 8; i++) bus8[i] = 16'h0000;
        bus8[0] = 16'hA5A5; sel8 = 3'd0; #1;
        check("bnd_sel0", out8, 16'hA5A5);
        bus8[7] = 16'h5A5A; sel8 = 3'd7; #1;
        check("bnd_sel7", out8, 16'h5A5A);

        // Registered path: load, then hold with enable low.
        @(negedge clk);
        sel8 = 3'd3; bus8[3] = 16'h1234; en8 = 1'b1;
        edge_then_settle();
        check("reg_load_q", q8, 16'h1234);
        check("reg_load_v", v8, 1'b1);
        @(negedge clk);
        bus8[3] = 16'hFFFF; en8 = 1'b0;
        edge_then_settle();
        check("reg_hold_q",   q8,   16'h1234);
        check("reg_hold_out", out8, 16'hFFFF);

        // Async reset mid-cycle, no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        check("arst_q",   q8,   16'h0000);
        check("arst_v",   v8,   1'b0);
        check("arst_out", out8, 16'hFFFF);
        bus8[3] = 16'h4321;
        #1;
        check("arst_out_track", out8, 16'h4321);
        @(negedge clk);
        en8 = 1'b1;
        edge_then_settle();
        check("arst_held_q", q8, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        edge_then_settle();
        check("arst_reload_q", q8, 16'h4321);
        check("arst_reload_v", v8, 1'b1);
        @(negedge clk);
        en8 = 1'b0;

        // Out of range on the 5-input mux.
        bus5[2] = 16'h0C0C; sel5 = 3'd2; en5 = 1'b1;
        edge_then_settle();
        check("oor_pre_v", v5, 1'b1);
        @(negedge clk);
        sel5 = 3'd6;
        #1;
        check("oor_out", out5, 16'hDEAD);
        check("oor_err", err5, 1'b1);
        edge_then_settle();
        check("oor_v", v5, 1'b0);
        check("oor_q", q5, 16'hDEAD);
        exp_q = 16'hDEAD;
        exp_v = 1'b0;

        // Randomized registered traffic on the 5-input mux, including out-of-range selects.
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) bus5[i] = 16'($urandom);
            s    = $urandom_range(0, 7);
            sel5 = 3'(s);
            en5  = 1'($urandom_range(0, 1));
            #1;
            word = model5(s, bus5);
            check($sformatf("rnd5_out[%0d]", it), out5, word);
            check($sformatf("rnd5_err[%0d]", it), err5, (s >= 5));
            if (en5) begin
                exp_q = word;
                exp_v = (s < 5);
            end
            edge_then_settle();
            check($sformatf("rnd5_q[%0d]", it), q5, exp_q);
            check($sformatf("rnd5_v[%0d]", it), v5, exp_v);
        end

        // Degenerate single-input configuration.
        @(negedge clk);
        en5 = 1'b0;
        bus1[0] = 16'h00FF; sel1 = 1'b0; en1 = 1'b1;
        #1;
        check("deg_out0", out1, 16'h00FF);
        check("deg_err0", err1, 1'b0);
        edge_then_settle();
        check("deg_q0", q1, 16'h00FF);
        check("deg_v0", v1, 1'b1);
        @(negedge clk);
        sel1 = 1'b1;
        #1;
        check("deg_out1", out1, 16'hBEEF);
        check("deg_err1", err1, 1'b1);
        edge_then_settle();
        check("deg_q1", q1, 16'hBEEF);
        check("deg_v1", v1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
